// File: rtl/perf_event_counters_if.sv
// Register-access bus for the performance event counter block.
// The master issues write/read strobes with an address and write data;
// the slave answers reads one cycle later with rdata qualified by rvalid.
interface perf_event_counters_if;
  logic        cfg_we;
  logic        cfg_re;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        cfg_rvalid;

  modport master (
    output cfg_we,
    output cfg_re,
    output cfg_addr,
    output cfg_wdata,
    input  cfg_rdata,
    input  cfg_rvalid
  );

  modport slave (
    input  cfg_we,
    input  cfg_re,
    input  cfg_addr,
    input  cfg_wdata,
    output cfg_rdata,
    output cfg_rvalid
  );
endinterface

// File: rtl/perf_event_counters.sv
// Bank of software-configurable event counters.
// Each counter selects one bit of the event vector, counts it while enabled,
// flags a sticky overflow on wrap and can raise a level interrupt.
// Wide counters are read atomically: reading CNT_LO snapshots the upper bits
// into one shared shadow register that any CNT_HI read then returns.
module perf_event_counters #(
  parameter int NUM_COUNTERS  = 4,
  parameter int COUNTER_WIDTH = 48,
  parameter int NUM_EVENTS    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_EVENTS-1:0] events,
  perf_event_counters_if.slave  cfg,
  output logic                  overflow_irq
);
  localparam int HI_W = COUNTER_WIDTH - 32;

  logic                     global_en;
  logic [7:0]               event_sel [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0]  cnt_en;
  logic [NUM_COUNTERS-1:0]  irq_en;
  logic [NUM_COUNTERS-1:0]  ovf;
  logic [COUNTER_WIDTH-1:0] cnt [NUM_COUNTERS];
  logic [HI_W-1:0]          shadow;

  // Zero-padding to 256 bits makes any selector beyond NUM_EVENTS read a 0.
  logic [255:0]             events_pad;
  logic                     wr_gctrl;
  logic                     wr_ovf;
  logic                     clear_all;
  logic [NUM_COUNTERS-1:0]  wr_cfg;
  logic [NUM_COUNTERS-1:0]  wr_lo;
  logic [NUM_COUNTERS-1:0]  wr_hi;
  logic [NUM_COUNTERS-1:0]  inc;
  logic [NUM_COUNTERS-1:0]  wrap;
  logic [31:0]              rd_val;
  logic                     rd_lo;
  logic [HI_W-1:0]          rd_lo_hi;

  assign events_pad   = 256'(events);
  assign wr_gctrl     = cfg.cfg_we && (cfg.cfg_addr == 8'h00);
  assign wr_ovf       = cfg.cfg_we && (cfg.cfg_addr == 8'h01);
  assign clear_all    = wr_gctrl && cfg.cfg_wdata[1];
  assign overflow_irq = |(ovf & irq_en);

  // Per-counter write decode and increment/wrap qualification; a register write wins over an increment
  always_comb begin
    wr_cfg = '0;
    wr_lo  = '0;
    wr_hi  = '0;
    inc    = '0;
    wrap   = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (cfg.cfg_we && (cfg.cfg_addr[7:2] == 6'(i + 1))) begin
        wr_cfg[i] = (cfg.cfg_addr[1:0] == 2'd0);
        wr_lo[i]  = (cfg.cfg_addr[1:0] == 2'd1);
        wr_hi[i]  = (cfg.cfg_addr[1:0] == 2'd2);
      end
      inc[i]  = global_en && cnt_en[i] && events_pad[event_sel[i]] && !wr_lo[i] && !wr_hi[i];
      wrap[i] = inc[i] && (&cnt[i]);
    end
  end

  // Read mux over pre-edge state; a CNT_LO hit also supplies the upper bits for the shadow
  always_comb begin
    rd_val   = '0;
    rd_lo    = 1'b0;
    rd_lo_hi = '0;
    if (cfg.cfg_addr == 8'h00) begin
      rd_val = {31'b0, global_en};
    end else if (cfg.cfg_addr == 8'h01) begin
      rd_val = 32'(ovf);
    end
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (cfg.cfg_addr[7:2] == 6'(i + 1)) begin
        case (cfg.cfg_addr[1:0])
          2'd0: rd_val = {22'b0, irq_en[i], cnt_en[i], event_sel[i]};
          2'd1: begin
            rd_val   = cnt[i][31:0];
            rd_lo    = 1'b1;
            rd_lo_hi = cnt[i][COUNTER_WIDTH-1:32];
          end
          2'd2:    rd_val = 32'(shadow);
          default: rd_val = '0;
        endcase
      end
    end
  end

  // Counter values and per-counter configuration; clear_all zeroes counts but leaves configuration alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        cnt[i]       <= '0;
        event_sel[i] <= '0;
      end
      cnt_en <= '0;
      irq_en <= '0;
    end else begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        if (wr_cfg[i]) begin
          event_sel[i] <= cfg.cfg_wdata[7:0];
          cnt_en[i]    <= cfg.cfg_wdata[8];
          irq_en[i]    <= cfg.cfg_wdata[9];
        end
        if (clear_all) begin
          cnt[i] <= '0;
        end else if (wr_lo[i]) begin
          cnt[i][31:0] <= cfg.cfg_wdata;
        end else if (wr_hi[i]) begin
          cnt[i][COUNTER_WIDTH-1:32] <= cfg.cfg_wdata[HI_W-1:0];
        end else if (inc[i]) begin
          cnt[i] <= cnt[i] + COUNTER_WIDTH'(1);
        end
      end
    end
  end

  // Global enable, sticky overflow flags (new wrap beats W1C), shadow capture and the one-cycle read response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      global_en      <= 1'b0;
      ovf            <= '0;
      shadow         <= '0;
      cfg.cfg_rvalid <= 1'b0;
      cfg.cfg_rdata  <= '0;
    end else begin
      if (wr_gctrl) begin
        global_en <= cfg.cfg_wdata[0];
      end
      if (clear_all) begin
        ovf <= '0;
      end else begin
        ovf <= (ovf & ~(wr_ovf ? cfg.cfg_wdata[NUM_COUNTERS-1:0] : '0)) | wrap;
      end
      if (cfg.cfg_re && rd_lo) begin
        shadow <= rd_lo_hi;
      end
      cfg.cfg_rvalid <= cfg.cfg_re;
      cfg.cfg_rdata  <= cfg.cfg_re ? rd_val : '0;
    end
  end
endmodule

// File: tb/tb_perf_event_counters.sv
// Scoreboard bench for perf_event_counters: a register-level reference
// model predicts every read response and the interrupt level; a monitor
// matches responses against the expected queue as they arrive.
module tb_perf_event_counters;
  localparam int NC = 4;
  localparam int W  = 48;
  localparam int NE = 32;
  localparam bit [63:0] MASK = (W == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << W) - 64'd1);
  localparam bit [NE-1:0] EV0 = '0;
  localparam bit [NE-1:0] EV5 = NE'(32'h20);
  localparam bit [NE-1:0] EV7 = NE'(32'h80);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NE-1:0] events = '0;
  logic          overflow_irq;

  perf_event_counters_if bus ();

  perf_event_counters #(
    .NUM_COUNTERS (NC),
    .COUNTER_WIDTH(W),
    .NUM_EVENTS   (NE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .events      (events),
    .cfg         (bus.slave),
    .overflow_irq(overflow_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [7:0]  addr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // Reference model state, expressed as plain register contents
  bit [63:0]   m_cnt [NC];
  bit [7:0]    m_sel [NC];
  bit          m_en  [NC];
  bit          m_irq [NC];
  bit          m_gen;
  bit [NC-1:0] m_ovf;
  bit [63:0]   m_shadow;

  // Cycle counter used to time-stamp expected read responses
  always @(posedge clk) cyc <= cyc + 1;

  task automatic modelReset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = '0;
      m_sel[i] = '0;
      m_en[i]  = 1'b0;
      m_irq[i] = 1'b0;
    end
    m_gen    = 1'b0;
    m_ovf    = '0;
    m_shadow = '0;
  endtask

  function automatic bit modelIrqLevel();
    bit r = 1'b0;
    for (int i = 0; i < NC; i++) r = r | (m_ovf[i] & m_irq[i]);
    return r;
  endfunction

  function automatic logic [31:0] modelRead(bit [7:0] addr);
    int a = int'(addr);
    int idx;
    int off;
    if (a == 0) return {31'b0, m_gen};
    if (a == 1) return 32'(m_ovf);
    if (a >= 4 && a < 4 + 4 * NC) begin
      idx = (a - 4) / 4;
      off = a % 4;
      if (off == 0) return {22'b0, m_irq[idx], m_en[idx], m_sel[idx]};
      if (off == 1) return m_cnt[idx][31:0];
      if (off == 2) return m_shadow[31:0];
    end
    return 32'h0;
  endfunction

  task automatic modelStep(bit we, bit re, bit [7:0] addr, bit [31:0] wd, bit [NE-1:0] ev);
    bit [63:0]   nc [NC];
    bit [NC-1:0] novf;
    int          a = int'(addr);
    bit          in_ctr = (a >= 4) && (a < 4 + 4 * NC);
    int          idx = (a - 4) / 4;
    int          off = a % 4;
    bit          counting;
    if (re && in_ctr && off == 1) m_shadow = m_cnt[idx] >> 32;
    novf = m_ovf;
    if (we && a == 1) novf = novf & ~wd[NC-1:0];
    for (int i = 0; i < NC; i++) begin
      counting = 1'b0;
      if (m_gen && m_en[i] && int'(m_sel[i]) < NE) counting = ev[m_sel[i]];
      nc[i] = m_cnt[i];
      if (we && in_ctr && idx == i && off == 1) begin
        nc[i] = {m_cnt[i][63:32], wd};
      end else if (we && in_ctr && idx == i && off == 2) begin
        nc[i] = (({32'b0, wd} << 32) | {32'b0, m_cnt[i][31:0]}) & MASK;
      end else if (counting) begin
        nc[i] = (m_cnt[i] + 64'd1) & MASK;
        if (nc[i] == 64'd0) novf[i] = 1'b1;
      end
    end
    if (we && a == 0 && wd[1]) begin
      for (int i = 0; i < NC; i++) nc[i] = '0;
      novf = '0;
    end
    if (we && in_ctr && off == 0) begin
      m_sel[idx] = wd[7:0];
      m_en[idx]  = wd[8];
      m_irq[idx] = wd[9];
    end
    if (we && a == 0) m_gen = wd[0];
    for (int i = 0; i < NC; i++) m_cnt[i] = nc[i];
    m_ovf = novf;
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: match each read response with its expected entry; otherwise the bus must be idle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      total++;
      if (bus.cfg_rvalid !== 1'b1) begin
        bad++;
        $display("[TB] FAIL rvalid_missing addr=%h: got rvalid=%b expected 1", e.addr, bus.cfg_rvalid);
      end else if (bus.cfg_rdata !== e.data) begin
        bad++;
        $display("[TB] FAIL rdata addr=%h: got %h expected %h", e.addr, bus.cfg_rdata, e.data);
      end
    end else begin
      total++;
      if (bus.cfg_rvalid !== 1'b0 || bus.cfg_rdata !== 32'h0) begin
        bad++;
        $display("[TB] FAIL idle_bus: got rvalid=%b rdata=%h expected 0/0", bus.cfg_rvalid, bus.cfg_rdata);
      end
    end
  end

  task automatic applyStimulus(bit we, bit re, bit [7:0] addr, bit [31:0] wd, bit [NE-1:0] ev);
    @(negedge clk);
    bus.cfg_we    = we;
    bus.cfg_re    = re;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = wd;
    events        = ev;
    if (re) exp_q.push_back('{cyc + 1, modelRead(addr), addr});
    modelStep(we, re, addr, wd, ev);
    @(posedge clk);
    #1;
    checkOutput("overflow_irq", 32'(overflow_irq), 32'(modelIrqLevel()));
  endtask

  task automatic wr(bit [7:0] addr, bit [31:0] wd, bit [NE-1:0] ev = '0);
    applyStimulus(1'b1, 1'b0, addr, wd, ev);
  endtask

  task automatic rd(bit [7:0] addr);
    applyStimulus(1'b0, 1'b1, addr, 32'h0, EV0);
  endtask

  task automatic readAll();
    for (int a = 0; a < 4 + 4 * NC; a++) rd(8'(a));
  endtask

  function automatic bit [31:0] shapeData(bit [7:0] a);
    bit [31:0] d = $urandom;
    if (a == 8'h00) begin
      d = 32'h1 | (($urandom_range(0, 15) == 0) ? 32'h2 : 32'h0);
    end else if (a >= 8'h04 && a[1:0] == 2'd0) begin
      d = {22'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 40))};
    end else if (a >= 8'h04 && a[1:0] == 2'd1) begin
      d = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
    end else if (a >= 8'h04 && a[1:0] == 2'd2) begin
      d = ($urandom_range(0, 1) == 1) ? 32'h0000_FFFF : d;
    end
    return d;
  endfunction

  // Watchdog so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit        we;
    bit        re;
    bit [7:0]  a;
    bit [31:0] d;
    int        r;
    bus.cfg_we    = 1'b0;
    bus.cfg_re    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_irq", 32'(overflow_irq), 32'h0);
    checkOutput("reset_rvalid", 32'(bus.cfg_rvalid), 32'h0);
    checkOutput("reset_rdata", bus.cfg_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    readAll();

    // Basic counting with a toggling neighbour event
    wr(8'h04, 32'h105);
    wr(8'h00, 32'h1);
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, EV5 | ((k % 2 == 1) ? NE'(32'h10) : EV0));
    rd(8'h05);
    checkOutput("cnt0_after_10", 32'(m_cnt[0]), 32'd10);
    rd(8'h09);
    rd(8'h0D);
    rd(8'h11);

    // Wrap of a 48-bit counter raises ovf and the interrupt; W1C drops it
    wr(8'h08, 32'h307);
    wr(8'h0A, 32'h0000_FFFF);
    wr(8'h09, 32'hFFFF_FFFE);
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, EV7);
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, EV7);
    checkOutput("wrap_irq_set", 32'(overflow_irq), 32'h1);
    rd(8'h09);
    rd(8'h0A);
    rd(8'h01);
    wr(8'h01, 32'h2);
    checkOutput("wrap_irq_cleared", 32'(overflow_irq), 32'h0);

    // Counter write beats a coincident increment
    wr(8'h05, 32'h1234, EV5);
    rd(8'h05);

    // Shadow keeps the upper bits seen by the LO read
    wr(8'h06, 32'h1);
    wr(8'h05, 32'hFFFF_FFFF);
    rd(8'h05);
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, EV5);
    rd(8'h06);

    // clear_all on the same edge as an overflow
    wr(8'h0A, 32'h0000_FFFF);
    wr(8'h09, 32'hFFFF_FFFF);
    wr(8'h00, 32'h3, EV7);
    checkOutput("clear_irq", 32'(overflow_irq), 32'h0);
    rd(8'h01);
    rd(8'h05);
    rd(8'h09);
    rd(8'h00);

    // Coincident write and read returns the pre-write value
    applyStimulus(1'b1, 1'b1, 8'h0C, 32'h2AB, EV0);
    rd(8'h0C);

    // Reserved and unmapped addresses
    wr(8'h07, 32'hFFFF_FFFF);
    wr(8'h14, 32'hFFFF_FFFF);
    wr(8'h02, 32'hFFFF_FFFF);
    foreach (exp_q[i]) begin end
    rd(8'h02);
    rd(8'h03);
    rd(8'h07);
    rd(8'h14);
    rd(8'h40);
    rd(8'hFF);

    // Randomized register traffic with random events
    for (int k = 0; k < 400; k++) begin
      r  = $urandom_range(0, 21);
      a  = (r < 18) ? 8'(r) : 8'($urandom_range(0, 255));
      we = ($urandom_range(0, 9) < 4);
      re = ($urandom_range(0, 1) == 1);
      d  = shapeData(a);
      applyStimulus(we, re, a, d, NE'($urandom));
    end
    readAll();

    // Reset asserted between a read request and its response
    @(negedge clk);
    bus.cfg_we   = 1'b0;
    bus.cfg_re   = 1'b1;
    bus.cfg_addr = 8'h05;
    events       = '0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("rst_rvalid_suppressed", 32'(bus.cfg_rvalid), 32'h0);
    bus.cfg_re = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_irq", 32'(overflow_irq), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    readAll();

    // Counting stays off until software enables it again
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, '1);
    rd(8'h05);
    rd(8'h09);

    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, EV0);
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, EV0);
    checkOutput("pending_responses", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/perf_event_counters.md
PERF_EVENT_COUNTERS -- requirements
Module: perf_event_counters

Interface
REQ-001 SHALL have parameter NUM_COUNTERS, default 4, number of independent event counters (1..16).
REQ-002 SHALL have parameter COUNTER_WIDTH, default 48, counter width in bits (33..64).
REQ-003 SHALL have parameter NUM_EVENTS, default 32, width of the event input vector (1..256).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port events  input  NUM_EVENTS  one-cycle event pulses (flattened cva5_trace_events_t, zero-padded).
REQ-007 SHALL have port cfg_we  input  1  register write strobe.
REQ-008 SHALL have port cfg_re  input  1  register read strobe.
REQ-009 SHALL have port cfg_addr  input  8  word address.
REQ-010 SHALL have port cfg_wdata  input  32  write data.
REQ-011 SHALL have port cfg_rdata  output  32  read data, valid with cfg_rvalid.
REQ-012 SHALL have port cfg_rvalid  output  1  read response strobe.
REQ-013 SHALL have port overflow_irq  output  1  level interrupt: OR over i of (ovf[i] AND irq_en[i]).

Function
REQ-014 Address map SHALL be: 0x00 GCTRL (bit0 global_en, bit1 clear_all, write-1 self-clearing, reads 0); 0x01 OVF (bit i = ovf[i], write-1-to-clear); counter i at base 0x04+4i: +0 CFG (bits7:0 event_sel, bit8 en, bit9 irq_en), +1 CNT_LO (bits 31:0), +2 CNT_HI (bits COUNTER_WIDTH-1:32, zero-extended), +3 reserved.
REQ-015 Unmapped or reserved addresses SHALL read 0, and writes to them SHALL be ignored.
REQ-016 Counter i SHALL increment by 1 on a clock edge when global_en, en[i] and events[event_sel[i]] are all 1 at that edge.
REQ-017 event_sel[i] >= NUM_EVENTS SHALL never count.
REQ-018 Counter increment SHALL be modulo 2^COUNTER_WIDTH; on the increment from all-ones to 0, ovf[i] SHALL be set on the same edge.
REQ-019 A write to CNT_LO or CNT_HI SHALL replace that field on the edge; a coincident increment of that counter in that cycle SHALL be discarded.
REQ-020 clear_all SHALL zero every counter and every ovf bit on the write edge, overriding coincident increments and overflows; CFG and global_en SHALL be unaffected.
REQ-021 On coincident OVF W1C and new overflow of the same bit, set SHALL win.
REQ-022 Read latency SHALL be 1 cycle: cfg_rvalid=1 exactly one cycle after cfg_re, with cfg_rdata reflecting register state before that edge's updates.
REQ-023 cfg_rvalid SHALL be 0 in any cycle not following a cfg_re; cfg_rdata SHALL be 0 when cfg_rvalid=0.
REQ-024 A read of CNT_LO of counter i SHALL latch bits COUNTER_WIDTH-1:32 of that counter into a single shared shadow register.
REQ-025 A read of CNT_HI of any counter SHALL return the shadow register contents, giving atomic wide reads via the LO-then-HI read order.
REQ-026 Coincident cfg_we and cfg_re SHALL both be serviced; the read SHALL return the pre-write value.
REQ-027 Event sampling SHALL add no pipeline delay: an event present at edge t SHALL be visible in a read issued at cycle t+1.
REQ-028 overflow_irq SHALL be combinational from registered ovf and irq_en, with no added latency.

Reset
REQ-029 While rst_n=0, all counters, ovf, CFG fields, global_en and the shadow register SHALL be 0.
REQ-030 While rst_n=0, cfg_rvalid, cfg_rdata and overflow_irq SHALL be 0.
REQ-031 Reset asserted mid-read SHALL suppress the pending cfg_rvalid.
REQ-032 After rst_n deasserts, counting SHALL resume only after software sets global_en and en[i].

Verification
REQ-033 Test: write CFG0=0x105 and GCTRL=1, then pulse events[5] for 10 cycles with events[4] toggling -> CNT_LO0 reads 10 and other counters read 0.
REQ-034 Test: with COUNTER_WIDTH=48, write CNT_HI1=0xFFFF and CNT_LO1=0xFFFFFFFE, set irq_en1, then apply 2 events -> count 0, OVF=0x2, overflow_irq=1; W1C 0x2 -> irq=0.
REQ-035 Test: apply a CNT_LO write and an event on the same edge -> the written value is held and the increment is lost.
REQ-036 Test: read CNT_LO while the counter is 0x1_FFFFFFFF, then increment, then read CNT_HI -> LO=0xFFFFFFFF and HI=0x1 from the shadow.
REQ-037 Test: assert clear_all on the same edge as an overflow -> all counts 0 and OVF=0.
REQ-038 Test: assert rst_n low asynchronously between cfg_re and cfg_rvalid -> no cfg_rvalid and all registers read 0 after reset.
